// File: rtl/sd_card_cmd_responder_pkg.sv
// Shared definitions for the SD card CMD-line responder.
// Holds the CRC7 polynomial, frame length, transmission-bit values,
// the FSM state encoding and a single-bit CRC7 step helper.
package sd_card_cmd_responder_pkg;

  // x^7 + x^3 + 1, implicit x^7 term dropped
  localparam logic [6:0] Crc7Poly = 7'h09;

  localparam int unsigned FrameBits = 48;

  localparam logic TxBitHost = 1'b1;  // host -> card
  localparam logic TxBitCard = 1'b0;  // card -> host

  typedef enum logic [2:0] {
    StIdle,
    StRecv,
    StCheck,
    StWait,
    StSend
  } state_e;

  // One serial CRC7 shift: MSB-first message bit enters the feedback.
  function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic bit_in);
    logic fb;
    fb = bit_in ^ crc[6];
    return {crc[5:0], 1'b0} ^ (fb ? Crc7Poly : 7'd0);
  endfunction

endpackage

// File: rtl/sd_crc7.sv
// Serial CRC7 generator/checker (x^7+x^3+1, initial value 0).
// Ports:
//   clock   - rising-edge clock
//   reset   - synchronous active-low reset
//   clear   - restart from zero; if enable is also high, bit_in is the first bit
//   enable  - fold bit_in into the running CRC this cycle
//   bit_in  - message bit, MSB first
//   crc     - running CRC remainder
module sd_crc7
  import sd_card_cmd_responder_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic       bit_in,
  output logic [6:0] crc
);

  logic [6:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clear) begin
      crc_d = enable ? crc7_step(7'd0, bit_in) : 7'd0;
    end else if (enable) begin
      crc_d = crc7_step(crc_q, bit_in);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/sd_card_cmd_responder.sv
// Card-side SD CMD line front-end. Receives 48-bit command frames, checks
// framing and CRC7, reports index/argument, then after RESP_DELAY clocks of
// turnaround drives a 48-bit R1-format response on the same line.
// Ports:
//   clock        - SD clock, rising edge
//   reset        - synchronous active-low reset
//   cmd_in       - resolved CMD line, sampled every clock
//   cmd_out      - value driven by the card (idle 1)
//   cmd_oe       - 1 while the card drives the line
//   card_status  - status word embedded in the R1 response
//   cmd_valid    - one-cycle pulse on a good command
//   cmd_index    - index of the last good command
//   cmd_arg      - argument of the last good command
//   crc_error    - one-cycle pulse on a rejected frame
//   busy         - high whenever the FSM is not idle
module sd_card_cmd_responder
  import sd_card_cmd_responder_pkg::*;
#(
  parameter int unsigned RESP_DELAY = 2,
  parameter int unsigned FRAME_BITS = FrameBits
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_in,
  output logic        cmd_out,
  output logic        cmd_oe,
  input  logic [31:0] card_status,
  output logic        cmd_valid,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  output logic        crc_error,
  output logic        busy
);

  // Counter serves the receive bit index, the turnaround wait and the send index.
  localparam int unsigned CntW = (RESP_DELAY > 64) ? $clog2(RESP_DELAY) : 6;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [46:0]     rx_q, rx_d;      // frame bits 46:0; start bit is implicit
  logic [39:0]     tx_q, tx_d;      // response bits 47:8, shifted out MSB first
  logic            cmd_out_q, cmd_out_d;
  logic            cmd_oe_q, cmd_oe_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic [5:0]      index_q, index_d;
  logic [31:0]     arg_q, arg_d;

  logic       rx_clr, rx_en;
  logic       tx_clr, tx_en;
  logic [6:0] rx_crc, tx_crc;
  logic       frame_good;

  sd_crc7 u_rx_crc (
    .clock  (clock),
    .reset  (reset),
    .clear  (rx_clr),
    .enable (rx_en),
    .bit_in (cmd_in),
    .crc    (rx_crc)
  );

  sd_crc7 u_tx_crc (
    .clock  (clock),
    .reset  (reset),
    .clear  (tx_clr),
    .enable (tx_en),
    .bit_in (tx_q[39]),
    .crc    (tx_crc)
  );

  assign frame_good = (rx_q[46] == TxBitHost) && rx_q[0] && (rx_q[7:1] == rx_crc);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    index_d   = index_q;
    arg_d     = arg_q;
    cmd_oe_d  = 1'b0;
    cmd_out_d = 1'b1;
    rx_clr    = 1'b0;
    rx_en     = 1'b0;
    tx_clr    = 1'b0;
    tx_en     = 1'b0;

    unique case (state_q)
      StIdle: begin
        rx_clr = 1'b1;
        if (!cmd_in) begin
          rx_en   = 1'b1;
          cnt_d   = CntW'(FRAME_BITS - 2);
          state_d = StRecv;
        end
      end
      StRecv: begin
        rx_d  = {rx_q[45:0], cmd_in};
        // CRC covers bits 47:8 only
        rx_en = (cnt_q >= CntW'(8));
        if (cnt_q == '0) begin
          state_d = StCheck;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StCheck: begin
        if (frame_good) begin
          valid_d = 1'b1;
          index_d = rx_q[45:40];
          arg_d   = rx_q[39:8];
          tx_d    = {1'b0, TxBitCard, rx_q[45:40], card_status};
          tx_clr  = 1'b1;
          cnt_d   = CntW'(RESP_DELAY - 2);
          state_d = StWait;
        end else begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          cnt_d   = CntW'(FRAME_BITS - 1);
          state_d = StSend;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StSend: begin
        // Line outputs are registered, so each bit appears one edge after
        // its index is presented here.
        cmd_oe_d = 1'b1;
        if (cnt_q >= CntW'(8)) begin
          cmd_out_d = tx_q[39];
          tx_en     = 1'b1;
          tx_d      = {tx_q[38:0], 1'b0};
        end else if (cnt_q != '0) begin
          cmd_out_d = tx_crc[cnt_q[2:0] - 3'd1];
        end
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      cmd_out_q <= 1'b1;
      cmd_oe_q  <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      index_q   <= '0;
      arg_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      cmd_out_q <= cmd_out_d;
      cmd_oe_q  <= cmd_oe_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      index_q   <= index_d;
      arg_q     <= arg_d;
    end
  end

  assign cmd_out   = cmd_out_q;
  assign cmd_oe    = cmd_oe_q;
  assign cmd_valid = valid_q;
  assign crc_error = err_q;
  assign cmd_index = index_q;
  assign cmd_arg   = arg_q;
  assign busy      = (state_q != StIdle);

endmodule
